wb_commit_sequencer: RTL
========================

# wb_commit_sequencer

Serialises the two-wide retire bundle leaving the memory stage onto the single architectural register-file write / debug-trace port, in program order. A 4-entry commit FIFO absorbs dual retires so the memory stage stalls only when the FIFO cannot take a full bundle. It sits between the memory-to-write pipeline register and the GPR write port. It replaces the stall-every-second-cycle scheme used for dual retire.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports (`sN` = slot 1 or 2):
- clk  in  1  sole clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; clears all state on the clock edge where it is sampled high.
- sN_valid  in  1  slot carries a retiring instruction.
- sN_pc  in  32  instruction PC.
- sN_dst  in  5  destination GPR.
- sN_value  in  32  write data.
- sN_wen  in  1  instruction writes a GPR.
- sN_exc  in  1  instruction raised an exception.
- sN_mtc0  in  1  instruction is MTC0.
- in_ready  out  1  bundle accepted this cycle if any sN_valid is set.
- w_pc  out  32  committed PC.
- w_reg  out  5  committed destination.
- w_value  out  32  committed data.
- w_enable  out  4  byte enables; all four bits identical.
- w_valid  out  1  a record is presented this cycle.
- occupancy  out  3  FIFO entry count, 0..DEPTH.

## Operation
- Record = {pc, dst, value, we}, where we = wen && !exc && !mtc0 && (dst != 0).
- Enqueue:
  - in_ready = (DEPTH − occupancy) >= 2. The count is taken before this cycle's dequeue, so the rule is deliberately conservative.
  - fire = in_ready && (s1_valid || s2_valid).
  - On fire, valid slots are written in order: slot 1 first, then slot 2.
  - A lone slot-2-valid bundle enqueues one record.
  - Invalid slots write nothing.
- Dequeue:
  - When occupancy > 0, the head is presented and popped on the same cycle. The write port never stalls.
  - w_valid = 1. w_pc, w_reg and w_value come from the head. w_enable = {4{head.we}}.
- Empty FIFO with no bypass: w_valid = 0 and all w_* outputs = 0.
- Same-cycle push and pop:
  - The count updates by +pushed − 1.
  - Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - A pushed entry never overwrites the entry being read that cycle. The in_ready rule guarantees this.
- Program order is strictly preserved: all slot-1 records precede slot-2 records, and all earlier bundles precede later ones.
- An exception or MTC0 record still occupies a slot and still presents its PC, with w_enable = 0.
- Reset:
  - Clears both pointers and the count.
  - Outputs after reset: occupancy = 0, w_valid = 0, w_* = 0, in_ready = 1.
  - A reset asserted mid-burst discards all queued records. No w_valid is produced on the reset cycle or the cycle after it.

## Timing
- Without bypass:
  - A record enqueued at edge N is presented in cycle N+1 at the earliest. It pops at edge N+1.
  - A dual bundle presents slot 1 in cycle N+1 and slot 2 in cycle N+2.
- Sustained throughput is 1 record per cycle. in_ready deasserts only when occupancy >= DEPTH−1.
- in_ready is a function of registered occupancy only. It has no combinational path from the sN inputs.
- w_* outputs are registered-state driven except in bypass mode.

## Configuration
- WB_COMMIT_BYPASS_EN defined:
  - If occupancy == 0 and fire with s1_valid, slot 1 is presented combinationally in the same cycle. It is not stored.
  - Slot 2, if valid, is enqueued alone.
  - A lone slot-2 bundle bypasses likewise.
  - Result: zero latency for the first record of a bundle into an empty FIFO.
- WB_COMMIT_BYPASS_EN undefined:
  - Every record passes through the FIFO.
  - Minimum latency is 1 cycle.
  - No combinational path from the sN inputs to the w_* outputs.

## Test plan
- Single retire, non-bypass: s1{pc=0xBFC00000, dst=3, value=0x1234, wen=1}.
  - Required: one cycle later, w_valid=1, w_reg=3, w_value=0x1234, w_enable=4'hF.
  - Required: next cycle, w_valid=0 and occupancy=0.
- Dual retire, pc 0x100 and 0x104.
  - Required: w_pc = 0x100 then 0x104 in consecutive cycles, with occupancy 2→1→0.
- Back-to-back dual bundles every cycle for 8 cycles.
  - Required: in_ready drops when occupancy reaches 3.
  - Required: all 16 PCs emerge in order with no gaps, one per cycle.
  - Required: occupancy never exceeds 4.
- Suppression cases: dst=0; exc=1; mtc0=1; wen=0.
  - Required: each emerges with its PC, w_valid=1, w_enable=4'h0.
- Reset mid-operation: assert reset with occupancy=3.
  - Required: the next cycle shows occupancy=0, w_valid=0, in_ready=1.
  - Required: no stale PC appears afterwards.
- With WB_COMMIT_BYPASS_EN, dual bundle into an empty FIFO.
  - Required: slot 1 appears on w_* in the same cycle.
  - Required: slot 2 appears the next cycle, with occupancy=1 in between.

Source files
------------

// File: rtl/wb_commit_sequencer_if.sv
// Retire-bundle / GPR write-port bundle for wb_commit_sequencer.
// The slave modport is the sequencer itself; master is the memory-stage / observer side.
interface wb_commit_sequencer_if;
   logic        s1_valid;
   logic [31:0] s1_pc;
   logic [4:0]  s1_dst;
   logic [31:0] s1_value;
   logic        s1_wen;
   logic        s1_exc;
   logic        s1_mtc0;
   logic        s2_valid;
   logic [31:0] s2_pc;
   logic [4:0]  s2_dst;
   logic [31:0] s2_value;
   logic        s2_wen;
   logic        s2_exc;
   logic        s2_mtc0;
   logic        in_ready;
   logic [31:0] w_pc;
   logic [4:0]  w_reg;
   logic [31:0] w_value;
   logic [3:0]  w_enable;
   logic        w_valid;
   logic [2:0]  occupancy;

   modport master (
      output s1_valid, s1_pc, s1_dst, s1_value, s1_wen, s1_exc, s1_mtc0,
      output s2_valid, s2_pc, s2_dst, s2_value, s2_wen, s2_exc, s2_mtc0,
      input  in_ready, w_pc, w_reg, w_value, w_enable, w_valid, occupancy
   );

   modport slave (
      input  s1_valid, s1_pc, s1_dst, s1_value, s1_wen, s1_exc, s1_mtc0,
      input  s2_valid, s2_pc, s2_dst, s2_value, s2_wen, s2_exc, s2_mtc0,
      output in_ready, w_pc, w_reg, w_value, w_enable, w_valid, occupancy
   );
endinterface

// File: rtl/wb_commit_sequencer.sv
// Serialises two-wide retire bundles onto the single GPR write port through a commit FIFO.
// Optional WB_COMMIT_BYPASS_EN: first record of a bundle into an empty FIFO is presented at once.
module wb_commit_sequencer #(
   parameter int unsigned DEPTH = 4
) (
   input logic                   clk,
   input logic                   reset,
   wb_commit_sequencer_if.slave  bus
);
   localparam int unsigned PtrW     = $clog2(DEPTH);
   // Two free entries are needed so a full bundle never lands on the entry being read.
   localparam logic [2:0]  ReadyMax = 3'(DEPTH - 2);

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  dst;
      logic [31:0] value;
      logic        we;
   } rec_t;

   rec_t            mem_q [DEPTH];
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [2:0]      count_q, count_d;
   rec_t            rec1, rec2, push_a, push_b, out_rec;
   logic [1:0]      n_push;
   logic            pop, fire, out_valid;

`ifdef WB_COMMIT_BYPASS_EN
   // Blocks bypass on the first cycle after reset so nothing is presented then.
   logic suppress_q;

   always_ff @(posedge clk) begin
      suppress_q <= reset;
   end
`endif

   assign rec1 = '{pc: bus.s1_pc, dst: bus.s1_dst, value: bus.s1_value,
                   we: bus.s1_wen && !bus.s1_exc && !bus.s1_mtc0 && (bus.s1_dst != 5'd0)};
   assign rec2 = '{pc: bus.s2_pc, dst: bus.s2_dst, value: bus.s2_value,
                   we: bus.s2_wen && !bus.s2_exc && !bus.s2_mtc0 && (bus.s2_dst != 5'd0)};

   assign bus.in_ready = (count_q <= ReadyMax);
   assign fire         = bus.in_ready && !reset && (bus.s1_valid || bus.s2_valid);

   always_comb begin
      push_a    = rec1;
      push_b    = rec2;
      n_push    = 2'd0;
      pop       = (count_q != 3'd0) && !reset;
      out_rec   = mem_q[rd_ptr_q];
      out_valid = pop;
      if (fire) begin
         if (bus.s1_valid && bus.s2_valid) begin
            n_push = 2'd2;
         end else begin
            n_push = 2'd1;
            if (!bus.s1_valid) push_a = rec2;
         end
      end
`ifdef WB_COMMIT_BYPASS_EN
      // Oldest record of the bundle goes straight out; the other (if any) is stored.
      if (fire && (count_q == 3'd0) && !suppress_q) begin
         out_rec   = push_a;
         out_valid = 1'b1;
         push_a    = push_b;
         n_push    = n_push - 2'd1;
      end
`endif
      rd_ptr_d = rd_ptr_q + PtrW'(pop);
      wr_ptr_d = wr_ptr_q + PtrW'(n_push);
      count_d  = count_q + 3'(n_push) - 3'(pop);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage needs no reset; occupancy qualifies every read.
   always_ff @(posedge clk) begin
      if (n_push != 2'd0) mem_q[wr_ptr_q] <= push_a;
      if (n_push == 2'd2) mem_q[wr_ptr_q + PtrW'(1)] <= push_b;
   end

   assign bus.w_valid   = out_valid;
   assign bus.w_pc      = out_valid ? out_rec.pc : 32'd0;
   assign bus.w_reg     = out_valid ? out_rec.dst : 5'd0;
   assign bus.w_value   = out_valid ? out_rec.value : 32'd0;
   assign bus.w_enable  = {4{out_valid && out_rec.we}};
   assign bus.occupancy = count_q;
endmodule
